// File: rtl/esm_issue_buffer.sv
// esm_issue_buffer
// Out-of-order issue buffer. Incoming instructions are written into the
// lowest free slot. Each slot ages for ISSUE_DELAY cycles so the
// dependency-analysis stage has time to settle. After that, the
// lowest-numbered slot that is free of dependencies is handed to the
// consumer through a registered valid/ready output stage.
module esm_issue_buffer #(
   parameter int Instruction_word_size = 32,
   parameter int bs                    = 16,
   parameter int ISSUE_DELAY           = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [Instruction_word_size-1:0] Instr_in,
   output logic [$clog2(bs)-1:0]            buffer_index,
   output logic [0:bs-1]                    valid_entries,
   input  logic [0:bs-1]                    independent_instr,
   output logic                             issue_valid,
   input  logic                             issue_ready,
   output logic [Instruction_word_size-1:0] issue_instr,
   output logic [$clog2(bs)-1:0]            issue_index,
   output logic [$clog2(bs):0]              occupancy
);

   localparam int IDX_W = $clog2(bs);
   localparam int CNT_W = IDX_W + 1;
   localparam int RES_W = (ISSUE_DELAY < 1) ? 1 : $clog2(ISSUE_DELAY + 1);
   localparam logic [RES_W-1:0] RES_MAX = RES_W'(ISSUE_DELAY);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   // Number of occupied slots in a mask.
   function automatic logic [CNT_W-1:0] popcount(input logic [0:bs-1] mask);
      logic [CNT_W-1:0] cnt;
      cnt = {CNT_W{1'b0}};
      for (int i = 0; i < bs; i++) begin
         cnt = cnt + CNT_W'(mask[i]);
      end
      return cnt;
   endfunction

   // Slot storage and per-slot bookkeeping
   logic [Instruction_word_size-1:0] mem_r      [0:bs-1];
   logic [RES_W-1:0]                 res_r      [0:bs-1];
   logic [0:bs-1]                    valid_r;
   logic [0:bs-1]                    inflight_r;

   // Output stage registers
   state_t                           state_r;
   state_t                           state_nxt_s;
   logic [Instruction_word_size-1:0] issue_instr_r;
   logic [IDX_W-1:0]                 issue_index_r;
   logic [CNT_W-1:0]                 occupancy_r;

   // Combinational control
   logic                             free_found_s;
   logic [IDX_W-1:0]                 alloc_idx_s;
   logic                             alloc_s;
   logic [0:bs-1]                    elig_s;
   logic                             sel_found_s;
   logic [IDX_W-1:0]                 sel_idx_s;
   logic                             load_s;
   logic                             free_s;
   logic [0:bs-1]                    alloc_oh_s;
   logic [0:bs-1]                    free_oh_s;
   logic [0:bs-1]                    load_oh_s;
   logic [0:bs-1]                    valid_nxt_s;

   // Find the lowest free slot. A slot released by a handshake in this
   // cycle is still marked valid, so it cannot be reused until the next cycle.
   always_comb begin
      free_found_s = 1'b0;
      alloc_idx_s  = {IDX_W{1'b0}};
      for (int i = bs - 1; i >= 0; i--) begin
         free_found_s = free_found_s | ~valid_r[i];
         alloc_idx_s  = valid_r[i] ? alloc_idx_s : IDX_W'(i);
      end
   end

   assign alloc_s = in_valid & free_found_s;

   // A slot is eligible once it is resident, not yet handed out,
   // dependency-free, and fully aged.
   always_comb begin
      elig_s = {bs{1'b0}};
      for (int i = 0; i < bs; i++) begin
         elig_s[i] = valid_r[i] & ~inflight_r[i] & independent_instr[i]
                     & (res_r[i] == RES_MAX);
      end
   end

   // Pick the lowest-numbered eligible slot.
   always_comb begin
      sel_found_s = 1'b0;
      sel_idx_s   = {IDX_W{1'b0}};
      for (int i = bs - 1; i >= 0; i--) begin
         sel_found_s = sel_found_s | elig_s[i];
         sel_idx_s   = elig_s[i] ? IDX_W'(i) : sel_idx_s;
      end
   end

   // Output FSM: decide when to load a new instruction and when to
   // release the held one.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      free_s      = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            if (sel_found_s) begin
               load_s      = 1'b1;
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_HOLD: begin
            if (issue_ready) begin
               free_s = 1'b1;
               if (sel_found_s) begin
                  load_s      = 1'b1;
                  state_nxt_s = ST_HOLD;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s = ST_EMPTY;
         end
      endcase
   end

   // Per-slot one-hot strobes for allocation, release and hand-out.
   always_comb begin
      alloc_oh_s = {bs{1'b0}};
      free_oh_s  = {bs{1'b0}};
      load_oh_s  = {bs{1'b0}};
      for (int i = 0; i < bs; i++) begin
         alloc_oh_s[i] = alloc_s & (alloc_idx_s   == IDX_W'(i));
         free_oh_s[i]  = free_s  & (issue_index_r == IDX_W'(i));
         load_oh_s[i]  = load_s  & (sel_idx_s     == IDX_W'(i));
      end
      valid_nxt_s = (valid_r | alloc_oh_s) & ~free_oh_s;
   end

   // Output-stage state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_EMPTY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Occupancy mask, residency counters, in-flight flags and the slot count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_r     <= {bs{1'b0}};
         inflight_r  <= {bs{1'b0}};
         occupancy_r <= {CNT_W{1'b0}};
         for (int i = 0; i < bs; i++) begin
            res_r[i] <= {RES_W{1'b0}};
         end
      end else begin
         valid_r     <= valid_nxt_s;
         occupancy_r <= popcount(valid_nxt_s);
         for (int i = 0; i < bs; i++) begin
            if (alloc_oh_s[i] || free_oh_s[i]) begin
               inflight_r[i] <= 1'b0;
               res_r[i]      <= {RES_W{1'b0}};
            end else begin
               if (load_oh_s[i]) begin
                  inflight_r[i] <= 1'b1;
               end
               if (valid_r[i] && (res_r[i] != RES_MAX)) begin
                  res_r[i] <= res_r[i] + RES_W'(1);
               end
            end
         end
      end
   end

   // Instruction payload storage. The valid mask guards every slot, so the
   // payload itself needs no reset.
   always_ff @(posedge clk) begin
      if (alloc_s) begin
         mem_r[alloc_idx_s] <= Instr_in;
      end
   end

   // Registered issue payload, loaded whenever a new slot is selected
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issue_instr_r <= {Instruction_word_size{1'b0}};
         issue_index_r <= {IDX_W{1'b0}};
      end else if (load_s) begin
         issue_instr_r <= mem_r[sel_idx_s];
         issue_index_r <= sel_idx_s;
      end
   end

   assign in_ready      = free_found_s;
   assign buffer_index  = alloc_idx_s;
   assign valid_entries = valid_r;
   assign issue_valid   = (state_r == ST_HOLD);
   assign issue_instr   = issue_instr_r;
   assign issue_index   = issue_index_r;
   assign occupancy     = occupancy_r;

endmodule

// File: tb/tb_esm_issue_buffer.sv
// Directed testbench for esm_issue_buffer (bs=16, ISSUE_DELAY=2).
module tb_esm_issue_buffer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr_in;
   logic [3:0]  buffer_index;
   logic [0:15] valid_entries;
   logic [0:15] independent_instr;
   logic        issue_valid;
   logic        issue_ready;
   logic [31:0] issue_instr;
   logic [3:0]  issue_index;
   logic [4:0]  occupancy;

   int cmp_cnt = 0;
   int err_cnt = 0;
   int n;

   esm_issue_buffer #(
      .Instruction_word_size(32),
      .bs(16),
      .ISSUE_DELAY(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .Instr_in(instr_in),
      .buffer_index(buffer_index),
      .valid_entries(valid_entries),
      .independent_instr(independent_instr),
      .issue_valid(issue_valid),
      .issue_ready(issue_ready),
      .issue_instr(issue_instr),
      .issue_index(issue_index),
      .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      cmp_cnt++;
      if (got !== want) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Occupancy mask with entry i at bit i.
   function automatic logic [31:0] vmask();
      logic [31:0] m;
      m = 32'h0;
      for (int i = 0; i < 16; i++) m[i] = valid_entries[i];
      return m;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst               = 1'b0;
      in_valid          = 1'b0;
      instr_in          = 32'h0;
      issue_ready       = 1'b0;
      independent_instr = 16'h0000;

      // Reset state, checked while reset is still asserted
      #2;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_buf_idx", 32'(buffer_index), 32'd0);
      check_eq("rst_issue_valid", 32'(issue_valid), 32'd0);
      check_eq("rst_occupancy", 32'(occupancy), 32'd0);
      check_eq("rst_mask", vmask(), 32'h0);
      check_eq("rst_issue_instr", issue_instr, 32'h0);
      check_eq("rst_issue_index", 32'(issue_index), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Single instruction through the buffer
      independent_instr = 16'hFFFF;
      issue_ready       = 1'b1;
      in_valid          = 1'b1;
      instr_in          = 32'h00A00093;
      check_eq("single_buf_idx", 32'(buffer_index), 32'd0);
      tick();
      in_valid = 1'b0;
      check_eq("single_mask", vmask(), 32'h1);
      check_eq("single_occ", 32'(occupancy), 32'd1);
      n = 0;
      while (!issue_valid && n < 10) begin
         tick();
         n++;
      end
      check_eq("single_latency", 32'(n), 32'd3);
      check_eq("single_instr", issue_instr, 32'h00A00093);
      check_eq("single_index", 32'(issue_index), 32'd0);
      tick();
      check_eq("single_freed_mask", vmask(), 32'h0);
      check_eq("single_freed_valid", 32'(issue_valid), 32'd0);
      check_eq("single_freed_occ", 32'(occupancy), 32'd0);

      // Fill all 16 slots, then try a 17th
      issue_ready       = 1'b0;
      independent_instr = 16'h0000;
      for (int k = 0; k < 16; k++) begin
         in_valid = 1'b1;
         instr_in = 32'h1000 + 32'(k);
         check_eq("fill_buf_idx", 32'(buffer_index), 32'(k));
         tick();
      end
      check_eq("fill_occ", 32'(occupancy), 32'd16);
      check_eq("fill_in_ready", 32'(in_ready), 32'd0);
      check_eq("fill_mask", vmask(), 32'hFFFF);
      instr_in = 32'hDEAD;
      tick();
      check_eq("over_occ", 32'(occupancy), 32'd16);
      check_eq("over_mask", vmask(), 32'hFFFF);
      check_eq("over_buf_idx", 32'(buffer_index), 32'd0);
      check_eq("over_issue_valid", 32'(issue_valid), 32'd0);
      in_valid = 1'b0;

      // Full buffer: free slot 5 while in_valid is high
      independent_instr[5] = 1'b1;
      tick();
      check_eq("sim_hold_valid", 32'(issue_valid), 32'd1);
      check_eq("sim_hold_index", 32'(issue_index), 32'd5);
      check_eq("sim_hold_instr", issue_instr, 32'h1005);
      issue_ready = 1'b1;
      in_valid    = 1'b1;
      instr_in    = 32'hBEEF;
      check_eq("sim_in_ready_full", 32'(in_ready), 32'd0);
      tick();
      check_eq("sim_occ_15", 32'(occupancy), 32'd15);
      check_eq("sim_mask_15", vmask(), 32'hFFDF);
      check_eq("sim_buf_idx", 32'(buffer_index), 32'd5);
      check_eq("sim_issue_idle", 32'(issue_valid), 32'd0);
      issue_ready       = 1'b0;
      independent_instr = 16'h0000;
      tick();
      in_valid = 1'b0;
      check_eq("sim_occ_16", 32'(occupancy), 32'd16);
      check_eq("sim_mask_16", vmask(), 32'hFFFF);

      // Stall on slot 3 for five cycles, then release and drain
      independent_instr[3] = 1'b1;
      tick();
      check_eq("stall_hold_index", 32'(issue_index), 32'd3);
      check_eq("stall_hold_instr", issue_instr, 32'h1003);
      independent_instr = 16'hFFFF;
      for (int k = 0; k < 5; k++) begin
         tick();
         check_eq("stall_index", 32'(issue_index), 32'd3);
         check_eq("stall_valid", 32'(issue_valid), 32'd1);
      end
      check_eq("stall_instr", issue_instr, 32'h1003);
      check_eq("stall_slot3_valid", vmask() & 32'h8, 32'h8);
      issue_ready = 1'b1;
      tick();
      check_eq("release_mask", vmask(), 32'hFFF7);
      check_eq("release_occ", 32'(occupancy), 32'd15);
      check_eq("b2b_idx0", 32'(issue_index), 32'd0);
      check_eq("b2b_instr0", issue_instr, 32'h1000);
      tick();
      check_eq("b2b_idx1", 32'(issue_index), 32'd1);
      tick();
      check_eq("b2b_idx2", 32'(issue_index), 32'd2);
      tick();
      check_eq("b2b_idx4", 32'(issue_index), 32'd4);
      tick();
      check_eq("b2b_idx5", 32'(issue_index), 32'd5);
      check_eq("b2b_instr5", issue_instr, 32'hBEEF);
      n = 0;
      while (issue_valid && n < 40) begin
         tick();
         n++;
      end
      check_eq("drain_done", 32'(issue_valid), 32'd0);
      check_eq("drain_mask", vmask(), 32'h0);
      check_eq("drain_occ", 32'(occupancy), 32'd0);

      // Priority and dependency gating on slots 0..3
      independent_instr = 16'h0000;
      issue_ready       = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         instr_in = 32'h2000 + 32'(k);
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      check_eq("dep_none_issued", 32'(issue_valid), 32'd0);
      independent_instr[1] = 1'b1;
      independent_instr[3] = 1'b1;
      tick();
      check_eq("dep_first_idx", 32'(issue_index), 32'd1);
      check_eq("dep_first_instr", issue_instr, 32'h2001);
      tick();
      check_eq("dep_second_idx", 32'(issue_index), 32'd3);
      check_eq("dep_second_instr", issue_instr, 32'h2003);
      tick();
      check_eq("dep_idle_valid", 32'(issue_valid), 32'd0);
      check_eq("dep_idle_mask", vmask(), 32'h5);
      tick();
      check_eq("dep_still_idle", 32'(issue_valid), 32'd0);
      independent_instr    = 16'h0000;
      independent_instr[2] = 1'b1;
      tick();
      check_eq("dep_third_idx", 32'(issue_index), 32'd2);
      check_eq("dep_third_instr", issue_instr, 32'h2002);
      independent_instr = 16'hFFFF;
      tick();
      check_eq("dep_fourth_idx", 32'(issue_index), 32'd0);
      check_eq("dep_fourth_instr", issue_instr, 32'h2000);
      tick();
      check_eq("dep_done_valid", 32'(issue_valid), 32'd0);
      check_eq("dep_done_mask", vmask(), 32'h0);

      // Asynchronous reset while holding, with six slots occupied
      independent_instr = 16'h0000;
      issue_ready       = 1'b0;
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1;
         instr_in = 32'h3000 + 32'(k);
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      independent_instr[0] = 1'b1;
      tick();
      check_eq("mid_hold_valid", 32'(issue_valid), 32'd1);
      check_eq("mid_hold_occ", 32'(occupancy), 32'd6);
      #2;
      rst = 1'b0;
      #1;
      check_eq("async_rst_valid", 32'(issue_valid), 32'd0);
      check_eq("async_rst_mask", vmask(), 32'h0);
      check_eq("async_rst_occ", 32'(occupancy), 32'd0);
      tick();
      rst               = 1'b1;
      independent_instr = 16'hFFFF;
      issue_ready       = 1'b1;
      repeat (4) tick();
      check_eq("post_rst_no_issue", 32'(issue_valid), 32'd0);
      check_eq("post_rst_mask", vmask(), 32'h0);
      check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("post_rst_buf_idx", 32'(buffer_index), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/esm_issue_buffer.md
ESM_ISSUE_BUFFER -- requirements
Module: esm_issue_buffer

Interface
REQ-001 Instruction_word_size, default 32, instruction word width in bits.
REQ-002 bs, default 16, number of buffer entries; power of two, minimum 4.
REQ-003 ISSUE_DELAY, default 2, minimum cycles an entry stays resident before it may issue; covers dependency-analysis latency.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  incoming instruction present.
REQ-007 in_ready  out  1  a free entry exists; combinational from current state.
REQ-008 Instr_in  in  Instruction_word_size  incoming instruction word.
REQ-009 buffer_index  out  $clog2(bs)  slot the incoming instruction is written to; drives the dependency-analysis stage.
REQ-010 valid_entries  out  [0:bs-1]  registered occupancy mask; bit i set = entry i holds an instruction.
REQ-011 independent_instr  in  [0:bs-1]  per-entry "no outstanding dependency" flags from the dependency-analysis stage.
REQ-012 issue_valid  out  1  issue_instr/issue_index hold a selected instruction.
REQ-013 issue_ready  in  1  consumer accepts the issued instruction.
REQ-014 issue_instr  out  Instruction_word_size  selected instruction word, registered.
REQ-015 issue_index  out  $clog2(bs)  entry number of the selected instruction, registered.
REQ-016 occupancy  out  $clog2(bs)+1  count of set bits in valid_entries, registered.

Function
REQ-017 buffer_index = lowest-numbered entry with valid_entries bit clear; 0 when full.
REQ-018 in_ready = 1 iff at least one valid_entries bit is clear.
REQ-019 Allocation on in_valid && in_ready: entry buffer_index stores Instr_in, valid bit set, residency counter cleared, in-flight flag cleared, at next edge.
REQ-020 Per-entry residency counter increments each cycle while valid; saturates at ISSUE_DELAY.
REQ-021 Entry eligible iff valid && !in-flight && independent_instr[i] && residency == ISSUE_DELAY.
REQ-022 Selection priority: lowest-numbered eligible entry.
REQ-023 Two-state output FSM: EMPTY (issue_valid=0), HOLD (issue_valid=1).
REQ-024 EMPTY -> HOLD when any entry eligible: load issue_instr/issue_index from the selected entry, set that entry's in-flight flag.
REQ-025 HOLD with issue_ready=0: issue_instr, issue_index, issue_valid held stable; no other entry selected.
REQ-026 HOLD with issue_ready=1: entry issue_index valid bit and in-flight flag cleared; if another entry eligible in the same cycle, it is loaded and FSM stays HOLD (back-to-back, one issue per cycle), else -> EMPTY.
REQ-027 Entry freed by handshake is not allocatable in the same cycle; allocation uses the pre-edge mask.
REQ-028 Allocation and free in the same cycle: occupancy unchanged.
REQ-029 Once in-flight, an entry ignores later changes of independent_instr.
REQ-030 Full (occupancy = bs): in_ready=0, in_valid ignored, no state change from the input side.
REQ-031 in_valid && !in_ready: no write, Instr_in dropped by this block; the producer holds it.

Reset
REQ-032 rst=0 asynchronously clears valid_entries, all residency counters and in-flight flags, occupancy=0, issue_valid=0, issue_instr=0, issue_index=0, FSM=EMPTY.
REQ-033 After reset: in_ready=1, buffer_index=0.
REQ-034 Reset mid-HOLD discards the pending instruction; nothing issues after release until new allocation.
REQ-035 First allocation possible on the first rising edge after rst deasserts.

Verification
REQ-036 Single instr: reset, 1 alloc of 0x00A00093 with independent_instr=all ones, issue_ready=1 -> buffer_index=0, issue_valid rises exactly ISSUE_DELAY+1 cycles after the alloc edge, issue_instr=0x00A00093, issue_index=0; valid_entries returns to all zeros.
REQ-037 Fill: bs allocs with issue_ready=0 -> slots 0..15 in order, occupancy=16, in_ready=0; 17th in_valid causes no change.
REQ-038 Stall: HOLD on entry 3, issue_ready=0 for 5 cycles -> issue_instr/issue_index stable, entry 3 still valid; on release, entry 3 freed next edge.
REQ-039 Priority/dependency: entries 0-3 resident, independent_instr=0101 (bits 0..3) -> issue order 1 then 3; entries 0 and 2 issue only after their bits set.
REQ-040 Simultaneous: full buffer, handshake frees entry 5 in the same cycle as in_valid -> no alloc that cycle; alloc to slot 5 next cycle; occupancy 16 -> 15 -> 16.
REQ-041 Reset mid-op: rst low during HOLD with 6 valid entries -> issue_valid=0, valid_entries=0, occupancy=0 immediately, without waiting for a clock edge.
